// File: rtl/rv32i_dmem_uart_bus_pkg.sv
// Shared constants and types for the RV32I data-side memory system.
// Holds the address map, the region-decode mask, the STATUS register bit
// positions and the UART transmitter state type.
package rv32i_soc_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;
  localparam logic [31:0] UART_TXDATA = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS = 32'h1000_0004;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/rv32i_dmem_uart_bus_if.sv
// Core data-port bus between the single-cycle RV32I core and the memory system.
// Signals: mem_we (store strobe), mem_addr (byte address), mem_wdata
// (unshifted store data), mem_wmask (unshifted byte mask), mem_rdata
// (combinational right-justified load data).
// master = core side, slave = memory system side.
interface rv32i_dmem_uart_bus_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport master (output mem_we, mem_addr, mem_wdata, mem_wmask, input mem_rdata);
  modport slave  (input mem_we, mem_addr, mem_wdata, mem_wmask, output mem_rdata);
endinterface

// File: rtl/rv32i_dmem_uart_bus_uart_tx.sv
// UART 8N1 transmitter with TX FIFO, baud down-counter and bit shifter.
// Ports: clk, reset_n (async active-low), push/push_data (enqueue; dropped
// when full), full, empty, count (FIFO occupancy), busy (FSM not IDLE),
// uart_tx (registered serial line, LSB first).
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, CLK_DIV cycles each, LSB first
// STOP  | stop bit (high); pops the next byte at its end for gapless frames
module rv32i_uart_tx
  import rv32i_soc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          uart_tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  uart_state_t   r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_tx, w_tx_nx;
  logic          w_pop, w_push_ok, w_baud_done;
  logic [7:0]    w_pop_data;

  assign full        = (r_count == CW'(FIFO_DEPTH));
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign busy        = (r_state != IDLE);
  assign uart_tx     = r_tx;
  // Fullness is judged before any same-cycle pop.
  assign w_push_ok   = push && !full;
  assign w_pop_data  = r_fifo[r_rd_ptr];
  assign w_baud_done = (r_baud == '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_pop_data;
          w_tx_nx    = 1'b0;
          w_baud_nx  = BAUD_RELOAD;
          w_state_nx = START;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_state_nx = DATA;
          w_bit_nx   = 3'd0;
          w_tx_nx    = r_shift[0];
          w_baud_nx  = BAUD_RELOAD;
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nx = BAUD_RELOAD;
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit + 1'b1;
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (!empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_pop_data;
            w_tx_nx    = 1'b0;
            w_baud_nx  = BAUD_RELOAD;
            w_state_nx = START;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_uart_bus.sv
// Data-side memory system for the single-cycle RV32I core.
// Decodes core loads/stores into a byte-addressable data RAM and a
// memory-mapped UART transmitter, and does the byte-lane steering the core
// omits (store data/mask arrive unshifted, loads leave right-justified).
// Ports: clk, reset_n (async active-low), bus (core data port, slave side),
// uart_tx (serial line, 8N1).
module rv32i_dmem_uart_bus
  import rv32i_soc_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rv32i_dmem_uart_bus_if.slave bus,
  output logic                 uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_ram [RAM_WORDS];
  logic          r_ovf;
  logic          w_sel_ram, w_sel_tx, w_sel_status, w_push;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [4:0]    w_shamt;
  logic [7:0]    w_mask_wide;
  logic [3:0]    w_lane_mask;
  logic [31:0]   w_wdata_sh, w_ram_word, w_status, w_rdata, w_count32;
  logic          w_full, w_empty, w_busy;
  logic [CW-1:0] w_count;
  logic [3:0]    w_cnt_disp;

  assign w_sel_ram    = ((bus.mem_addr & REGION_MASK) == RAM_BASE);
  assign w_sel_tx     = (bus.mem_addr == UART_TXDATA);
  assign w_sel_status = (bus.mem_addr == UART_STATUS);
  assign w_idx        = bus.mem_addr[AW+1:2];
  assign w_off        = bus.mem_addr[1:0];
  assign w_shamt      = {w_off, 3'b000};
  // Lanes shifted past byte 3 fall off the top, so misaligned stores never
  // spill into the next word.
  assign w_mask_wide  = {4'b0000, bus.mem_wmask} << w_off;
  assign w_lane_mask  = w_mask_wide[3:0];
  assign w_wdata_sh   = bus.mem_wdata << w_shamt;
  assign w_ram_word   = r_ram[w_idx];

  always_ff @(posedge clk) begin
    if (bus.mem_we && w_sel_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_mask[b]) r_ram[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign w_push = bus.mem_we && w_sel_tx && bus.mem_wmask[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_ovf <= 1'b0;
    else if (bus.mem_we && w_sel_status) r_ovf <= 1'b0;
    else if (w_push && w_full)           r_ovf <= 1'b1;
  end

  // Count field is only 4 bits wide; deeper FIFOs show 15.
  assign w_count32  = 32'(w_count);
  assign w_cnt_disp = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];

  always_comb begin
    w_status                 = '0;
    w_status[ST_FULL_BIT]    = w_full;
    w_status[ST_EMPTY_BIT]   = w_empty;
    w_status[ST_BUSY_BIT]    = w_busy;
    w_status[ST_OVF_BIT]     = r_ovf;
    w_status[ST_CNT_LSB +: 4] = w_cnt_disp;
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_ram)         w_rdata = w_ram_word >> w_shamt;
    else if (w_sel_status) w_rdata = w_status;
  end

  assign bus.mem_rdata = w_rdata;

  rv32i_uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CLK_DIV   (CLK_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_data(bus.mem_wdata[7:0]),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .busy     (w_busy),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_rv32i_dmem_uart_bus.sv
// Self-checking bench for rv32i_dmem_uart_bus: directed stores/loads and UART
// traffic, checked against a byte-level RAM model and a frame-position UART
// model, plus hand-computed literal expectations.
module tb_rv32i_dmem_uart_bus;
  import rv32i_soc_pkg::*;

  localparam int CD = 4;
  localparam int FD = 4;
  localparam int RW = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_tx;

  rv32i_dmem_uart_bus_if bus();

  rv32i_dmem_uart_bus #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_ram [RW*4];
  byte unsigned m_q[$];
  bit           m_active = 1'b0;
  int           m_pos = 0;
  byte unsigned m_cur = 8'h00;
  bit           m_ovf = 1'b0;

  function automatic bit m_exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CD;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n = m_q.size();
    s = 32'h0;
    s[0] = (n == FD);
    s[1] = (n == 0);
    s[2] = m_active;
    s[3] = m_ovf;
    s[11:8] = (n > 15) ? 4'hF : 4'(n);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] r;
    int base, off;
    r = 32'h0;
    if (addr[31:28] == 4'h0) begin
      base = ((addr >> 2) % RW) * 4;
      off  = int'(addr[1:0]);
      for (int k = 0; k < 4; k++)
        if (off + k < 4) r[8*k +: 8] = m_ram[base + off + k];
    end else if (addr == UART_STATUS) begin
      r = m_status();
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int n, base, off;
    byte unsigned v;
    if (!reset_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      n = m_q.size();
      if (m_active) begin
        if (m_pos == 10*CD - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (!m_active && n > 0) begin
        v = m_q.pop_front();
        m_cur = v;
        m_active = 1'b1;
        m_pos = 0;
      end
      if (bus.mem_we) begin
        if (bus.mem_addr == UART_TXDATA && bus.mem_wmask[0]) begin
          if (n == FD) m_ovf = 1'b1;
          else m_q.push_back(bus.mem_wdata[7:0]);
        end
        if (bus.mem_addr == UART_STATUS) m_ovf = 1'b0;
        if (bus.mem_addr[31:28] == 4'h0) begin
          base = ((bus.mem_addr >> 2) % RW) * 4;
          off  = int'(bus.mem_addr[1:0]);
          for (int i = 0; i < 4; i++)
            if (bus.mem_wmask[i] && off + i < 4)
              m_ram[base + off + i] = bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) chk("uart_tx_vs_model", {31'b0, uart_tx}, {31'b0, m_exp_tx()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_wmask = mask;
    @(negedge clk);
    bus.mem_we = 1'b0;
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [31:0] lit);
    @(negedge clk);
    bus.mem_we   = 1'b0;
    bus.mem_addr = addr;
    #1;
    chk({name, "_model"}, bus.mem_rdata, m_read(addr));
    chk(name, bus.mem_rdata, lit);
  endtask

  initial begin
    logic [9:0] frame;
    int low;

    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wmask = 4'h0;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_tx", {31'b0, uart_tx}, 32'h1);
    ld("reset_status", UART_STATUS, 32'h0000_0002);
    reset_n = 1'b1;

    // Lane steering
    st(32'h100, 32'hDEAD_BEEF, 4'b1111);
    ld("sw_load_100", 32'h100, 32'hDEAD_BEEF);
    ld("load_101", 32'h101, 32'h00DE_ADBE);
    ld("load_103", 32'h103, 32'h0000_00DE);
    st(32'h102, 32'h0000_0055, 4'b0001);
    ld("sb_102", 32'h100, 32'hDE55_BEEF);
    st(32'h103, 32'h0000_1234, 4'b0011);
    ld("sh_103_drop", 32'h100, 32'h3455_BEEF);
    ld("load_103_new", 32'h103, 32'h0000_0034);
    ld("wrap_503", 32'h503, 32'h0000_0034);

    // Single frame 0xA5
    frame = {1'b1, 8'hA5, 1'b0};
    st(UART_TXDATA, 32'h0000_00A5, 4'b0001);
    bus.mem_addr = UART_STATUS;
    for (int i = 0; i < 10*CD; i++) begin
      @(negedge clk);
      #1;
      chk("frame_a5_bit", {31'b0, uart_tx}, {31'b0, frame[i/CD]});
      if (i == 20) chk("busy_mid_frame", {31'b0, bus.mem_rdata[2]}, 32'h1);
    end
    ld("status_after_frame", UART_STATUS, 32'h0000_0002);

    // Six back-to-back pushes into a 4-entry FIFO
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mem_we    = 1'b1;
      bus.mem_addr  = UART_TXDATA;
      bus.mem_wdata = 32'h10 + k;
      bus.mem_wmask = 4'b0001;
    end
    @(negedge clk);
    bus.mem_we   = 1'b0;
    bus.mem_addr = UART_STATUS;
    #1;
    chk("status_ovf_full", bus.mem_rdata, 32'h0000_040D);
    chk("status_ovf_full_model", bus.mem_rdata, m_status());
    st(UART_STATUS, 32'h0, 4'b1111);
    ld("status_ovf_clr", UART_STATUS, 32'h0000_0405);
    low = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      #1;
      if (!bus.mem_rdata[2]) low++;
    end
    chk("busy_gaps", low, 0);
    ld("status_after_5", UART_STATUS, 32'h0000_0002);

    // Reset in the middle of a data bit, with a byte still queued
    st(UART_TXDATA, 32'h0000_003C, 4'b0001);
    st(UART_TXDATA, 32'h0000_0081, 4'b0001);
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_tx", {31'b0, uart_tx}, 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ld("status_after_reset", UART_STATUS, 32'h0000_0002);
    ld("ram_kept", 32'h100, 32'h3455_BEEF);
    repeat (50) @(negedge clk);

    // Unmapped region
    st(32'h0, 32'h1122_3344, 4'b1111);
    ld("ram_w0", 32'h0, 32'h1122_3344);
    ld("unmapped_rd", 32'h2000_0000, 32'h0);
    st(32'h2000_0000, 32'hFFFF_FFFF, 4'b1111);
    ld("ram_w0_kept", 32'h0, 32'h1122_3344);
    ld("txdata_rd", UART_TXDATA, 32'h0);
    ld("unmapped_1008", 32'h1000_0008, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
